// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding
// encodings, controller FSM states and the scoreboard entry layout.
package pipe_hazard_ctrl_pkg;

  // EX operand source selects
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  // Register indices are stored zero-extended to this width so the entry
  // layout stays fixed for any REG_W up to SB_RD_W.
  localparam int SB_RD_W = 8;

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_MEMWAIT = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic               valid;
    logic [SB_RD_W-1:0] rd;
    logic               regwrite;
    logic               memread;
    logic               memwrite;
  } sb_entry_t;

  // A source depends on an entry when it reads the entry's non-x0 destination.
  function automatic logic sb_match(input sb_entry_t e,
                                    input logic [SB_RD_W-1:0] rs,
                                    input logic used);
    return e.valid & e.regwrite & (e.rd != {SB_RD_W{1'b0}}) & (rs == e.rd) & used;
  endfunction

  // Youngest producer wins: EX/MEM ahead of MEM/WB.
  function automatic logic [1:0] fwd_sel(input sb_entry_t ex_e,
                                         input sb_entry_t mem_e,
                                         input logic [SB_RD_W-1:0] rs,
                                         input logic used);
    logic [1:0] sel;
    if (sb_match(ex_e, rs, used)) begin
      sel = FWD_EXMEM;
    end else if (sb_match(mem_e, rs, used)) begin
      sel = FWD_MEMWB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating event counter; sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clockCPU,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  // Count enabled events until the counter is full.
  always_ff @(posedge clockCPU or negedge reset) begin
    if (!reset) begin
      q <= {CNT_W{1'b0}};
    end else if (inc && (q != {CNT_W{1'b1}})) begin
      q <= q + CNT_W'(1'b1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall controller for the 5-stage RV32 pipeline: tracks
// in-flight destinations, registers EX forwarding selects and produces
// per-stage enable/flush/bubble controls.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_W          = 5,
  parameter int MEM_LAT        = 1,
  parameter int REDIRECT_STAGE = 0,
  parameter int CNT_W          = 16
) (
  input  logic             clockCPU,
  input  logic             reset,
  input  logic             id_valid,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_memwrite,
  input  logic             redirect,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_busy,
  output logic [CNT_W-1:0] lu_stalls,
  output logic [CNT_W-1:0] mem_stalls,
  output logic [CNT_W-1:0] flushes
);

  localparam int WAIT_W = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);
  localparam logic MULTI_CYC = (MEM_LAT > 1) ? 1'b1 : 1'b0;
  localparam logic EX_REDIR  = (REDIRECT_STAGE == 1) ? 1'b1 : 1'b0;

  hz_state_e          state_r, state_nxt_s;
  logic [WAIT_W-1:0]  wait_cnt_r, wait_cnt_nxt_s;
  logic               served_r, served_nxt_s;
  sb_entry_t          sb_r [0:2];
  sb_entry_t          id_entry_s, sb1_nxt_s;
  logic [1:0]         fwd_a_r, fwd_b_r;
  logic [SB_RD_W-1:0] rs1_ext_s, rs2_ext_s;
  logic               freeze_s, load_use_s, ex_redir_s, id_redir_s;
  logic               lu_inc_s;

  assign rs1_ext_s  = SB_RD_W'(id_rs1);
  assign rs2_ext_s  = SB_RD_W'(id_rs2);
  assign id_entry_s = {id_valid, SB_RD_W'(id_rd), id_regwrite, id_memread, id_memwrite};

  assign freeze_s   = (state_r == ST_MEMWAIT);
  assign load_use_s = id_valid & sb_r[0].memread &
                      (sb_match(sb_r[0], rs1_ext_s, id_rs1_used) |
                       sb_match(sb_r[0], rs2_ext_s, id_rs2_used));
  assign ex_redir_s = EX_REDIR & redirect;
  assign id_redir_s = ~EX_REDIR & redirect;
  assign lu_inc_s   = ~freeze_s & load_use_s & ~ex_redir_s;

  // What sb[1] will hold next cycle; a memory op landing there starts the wait.
  assign sb1_nxt_s  = freeze_s ? sb_r[1] : sb_r[0];

  assign fwd_a = fwd_a_r;
  assign fwd_b = fwd_b_r;

  // Stage controls: memory freeze > EX redirect > load-use > ID redirect.
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    mem_busy     = 1'b0;
    if (freeze_s) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
      mem_busy  = 1'b1;
    end else if (ex_redir_s) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (load_use_s) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_bubble = 1'b1;
    end else if (id_redir_s) begin
      if_id_flush = 1'b1;
    end else begin
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
    end
  end

  // Memory-wait FSM next state: hold MEM for MEM_LAT cycles per op.
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    served_nxt_s   = freeze_s ? served_r : 1'b0;
    case (state_r)
      ST_RUN: begin
        if (MULTI_CYC && sb1_nxt_s.valid && (sb1_nxt_s.memread || sb1_nxt_s.memwrite) &&
            !served_nxt_s) begin
          state_nxt_s    = ST_MEMWAIT;
          wait_cnt_nxt_s = WAIT_INIT;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_MEMWAIT: begin
        if (wait_cnt_r == {WAIT_W{1'b0}}) begin
          state_nxt_s  = ST_RUN;
          served_nxt_s = 1'b1;
        end else begin
          wait_cnt_nxt_s = wait_cnt_r - WAIT_W'(1'b1);
        end
      end
      default: begin
        state_nxt_s    = ST_RUN;
        wait_cnt_nxt_s = {WAIT_W{1'b0}};
        served_nxt_s   = 1'b0;
      end
    endcase
  end

  // FSM state, wait counter and served flag registers.
  always_ff @(posedge clockCPU or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_RUN;
      wait_cnt_r <= {WAIT_W{1'b0}};
      served_r   <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
      served_r   <= served_nxt_s;
    end
  end

  // Scoreboard shift and forwarding selects; both hold during a freeze.
  always_ff @(posedge clockCPU or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        sb_r[i] <= '0;
      end
      fwd_a_r <= FWD_RF;
      fwd_b_r <= FWD_RF;
    end else if (!freeze_s) begin
      sb_r[2] <= sb_r[1];
      sb_r[1] <= sb_r[0];
      if (id_ex_bubble) begin
        sb_r[0] <= '0;
        fwd_a_r <= FWD_RF;
        fwd_b_r <= FWD_RF;
      end else begin
        sb_r[0] <= id_entry_s;
        fwd_a_r <= fwd_sel(sb_r[0], sb_r[1], rs1_ext_s, id_rs1_used);
        fwd_b_r <= fwd_sel(sb_r[0], sb_r[1], rs2_ext_s, id_rs2_used);
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_lu_cnt (
    .clockCPU (clockCPU),
    .reset    (reset),
    .inc      (lu_inc_s),
    .q        (lu_stalls)
  );

  sat_counter #(.CNT_W(CNT_W)) u_mem_cnt (
    .clockCPU (clockCPU),
    .reset    (reset),
    .inc      (freeze_s),
    .q        (mem_stalls)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clockCPU (clockCPU),
    .reset    (reset),
    .inc      (if_id_flush),
    .q        (flushes)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomised bench for pipe_hazard_ctrl. Two configurations share the same
// stimulus: (MEM_LAT=3, EX redirect, 16-bit counters) and
// (MEM_LAT=1, ID redirect, 4-bit counters). A pipeline-occupancy model
// with a per-instruction memory-cycle countdown predicts every output.
module tb_pipe_hazard_ctrl;

  logic       clockCPU = 1'b0;
  logic       reset;
  logic       id_valid, id_rs1_used, id_rs2_used;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_regwrite, id_memread, id_memwrite, redirect;

  logic [1:0] pc_en_w, if_id_en_w, id_ex_en_w, ex_mem_en_w, mem_wb_en_w;
  logic [1:0] flush_w, bubble_w, busy_w;
  logic [1:0] fwd_a0, fwd_b0, fwd_a1, fwd_b1;
  logic [15:0] lu0, ms0, fl0;
  logic [3:0]  lu1, ms1, fl1;

  always #5 clockCPU = ~clockCPU;

  pipe_hazard_ctrl #(.REG_W(5), .MEM_LAT(3), .REDIRECT_STAGE(1), .CNT_W(16)) dut0 (
    .clockCPU(clockCPU), .reset(reset),
    .id_valid(id_valid), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .redirect(redirect),
    .pc_en(pc_en_w[0]), .if_id_en(if_id_en_w[0]), .id_ex_en(id_ex_en_w[0]),
    .ex_mem_en(ex_mem_en_w[0]), .mem_wb_en(mem_wb_en_w[0]),
    .if_id_flush(flush_w[0]), .id_ex_bubble(bubble_w[0]),
    .fwd_a(fwd_a0), .fwd_b(fwd_b0), .mem_busy(busy_w[0]),
    .lu_stalls(lu0), .mem_stalls(ms0), .flushes(fl0)
  );

  pipe_hazard_ctrl #(.REG_W(5), .MEM_LAT(1), .REDIRECT_STAGE(0), .CNT_W(4)) dut1 (
    .clockCPU(clockCPU), .reset(reset),
    .id_valid(id_valid), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .redirect(redirect),
    .pc_en(pc_en_w[1]), .if_id_en(if_id_en_w[1]), .id_ex_en(id_ex_en_w[1]),
    .ex_mem_en(ex_mem_en_w[1]), .mem_wb_en(mem_wb_en_w[1]),
    .if_id_flush(flush_w[1]), .id_ex_bubble(bubble_w[1]),
    .fwd_a(fwd_a1), .fwd_b(fwd_b1), .mem_busy(busy_w[1]),
    .lu_stalls(lu1), .mem_stalls(ms1), .flushes(fl1)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit v;
    int rd;
    bit rw;
    bit mr;
    bit mw;
  } ent_t;

  ent_t pipe [2][3];              // [cfg][EX, MEM, WB]
  int   mem_left [2];             // remaining MEM cycles of the op in MEM
  int   efa [2], efb [2];
  int   elu [2], ems [2], efl [2];
  int   lat_p [2]  = '{3, 1};
  bit   exr_p [2]  = '{1'b1, 1'b0};
  int   cmax [2]   = '{65535, 15};

  bit   m_fz [2], m_bub [2], m_fl [2], m_luinc [2];
  logic [7:0] m_ctl [2];

  function automatic bit hit(input ent_t e, input int rs, input bit used);
    return e.v && e.rw && (e.rd != 0) && (rs == e.rd) && used;
  endfunction

  function automatic int src_of(input ent_t ex_e, input ent_t mem_e, input int rs, input bit used);
    if (hit(ex_e, rs, used)) return 1;
    if (hit(mem_e, rs, used)) return 2;
    return 0;
  endfunction

  function automatic int sat_add(input int v, input bit inc, input int mx);
    return (inc && v < mx) ? v + 1 : v;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 3; s++) pipe[k][s] = '{default: 0};
      mem_left[k] = 0;
      efa[k] = 0; efb[k] = 0;
      elu[k] = 0; ems[k] = 0; efl[k] = 0;
    end
  endtask

  // Controls expected for the current inputs: {pc,ifid,idex,exmem,memwb,flush,bubble,busy}
  task automatic model_comb(input int k);
    bit lu, er, ir;
    m_fz[k] = pipe[k][1].v && (pipe[k][1].mr || pipe[k][1].mw) && (mem_left[k] > 1);
    lu = id_valid && pipe[k][0].mr &&
         (hit(pipe[k][0], int'(id_rs1), id_rs1_used) || hit(pipe[k][0], int'(id_rs2), id_rs2_used));
    er = exr_p[k] && redirect;
    ir = !exr_p[k] && redirect;
    if (m_fz[k]) begin
      m_ctl[k] = 8'b0000_0001; m_bub[k] = 1'b0; m_fl[k] = 1'b0;
    end else if (er) begin
      m_ctl[k] = 8'b1111_1110; m_bub[k] = 1'b1; m_fl[k] = 1'b1;
    end else if (lu) begin
      m_ctl[k] = 8'b0011_1010; m_bub[k] = 1'b1; m_fl[k] = 1'b0;
    end else begin
      m_ctl[k] = {5'b11111, ir, 2'b00}; m_bub[k] = 1'b0; m_fl[k] = ir;
    end
    m_luinc[k] = !m_fz[k] && lu && !er;
  endtask

  task automatic model_edge(input int k);
    ent_t nw;
    elu[k] = sat_add(elu[k], m_luinc[k], cmax[k]);
    ems[k] = sat_add(ems[k], m_fz[k], cmax[k]);
    efl[k] = sat_add(efl[k], m_fl[k], cmax[k]);
    if (!m_fz[k]) begin
      if (m_bub[k]) begin
        efa[k] = 0; efb[k] = 0;
        nw = '{default: 0};
      end else begin
        efa[k] = src_of(pipe[k][0], pipe[k][1], int'(id_rs1), id_rs1_used);
        efb[k] = src_of(pipe[k][0], pipe[k][1], int'(id_rs2), id_rs2_used);
        nw = '{v: id_valid, rd: int'(id_rd), rw: id_regwrite, mr: id_memread, mw: id_memwrite};
      end
      pipe[k][2] = pipe[k][1];
      pipe[k][1] = pipe[k][0];
      pipe[k][0] = nw;
      mem_left[k] = (pipe[k][1].v && (pipe[k][1].mr || pipe[k][1].mw)) ? lat_p[k] : 0;
    end else begin
      mem_left[k]--;
    end
  endtask

  function automatic logic [7:0] ctl_of(input int k);
    return {pc_en_w[k], if_id_en_w[k], id_ex_en_w[k], ex_mem_en_w[k], mem_wb_en_w[k],
            flush_w[k], bubble_w[k], busy_w[k]};
  endfunction

  task automatic check_regs(input string ph);
    check_eq({ph, "_fwd_a0"}, int'(fwd_a0), efa[0]);
    check_eq({ph, "_fwd_b0"}, int'(fwd_b0), efb[0]);
    check_eq({ph, "_fwd_a1"}, int'(fwd_a1), efa[1]);
    check_eq({ph, "_fwd_b1"}, int'(fwd_b1), efb[1]);
    check_eq({ph, "_lu0"}, int'(lu0), elu[0]);
    check_eq({ph, "_ms0"}, int'(ms0), ems[0]);
    check_eq({ph, "_fl0"}, int'(fl0), efl[0]);
    check_eq({ph, "_lu1"}, int'(lu1), elu[1]);
    check_eq({ph, "_ms1"}, int'(ms1), ems[1]);
    check_eq({ph, "_fl1"}, int'(fl1), efl[1]);
  endtask

  // One pipeline cycle: drive ID fields, check controls, clock, check registers.
  task automatic step(input bit v, input int r1, input bit a1, input int r2, input bit a2,
                      input int d, input bit w, input bit lr, input bit sw, input bit br);
    id_valid = v; id_rs1 = 5'(r1); id_rs1_used = a1; id_rs2 = 5'(r2); id_rs2_used = a2;
    id_rd = 5'(d); id_regwrite = w; id_memread = lr; id_memwrite = sw; redirect = br;
    #1;
    for (int k = 0; k < 2; k++) begin
      model_comb(k);
      check_eq($sformatf("ctl%0d", k), int'(ctl_of(k)), int'(m_ctl[k]));
    end
    @(posedge clockCPU);
    for (int k = 0; k < 2; k++) model_edge(k);
    #1;
    check_regs("seq");
  endtask

  // Asynchronous reset pulse, checked while asserted and released after one edge.
  task automatic do_reset();
    id_valid = 1'b0; id_rs1 = 5'd0; id_rs1_used = 1'b0; id_rs2 = 5'd0; id_rs2_used = 1'b0;
    id_rd = 5'd0; id_regwrite = 1'b0; id_memread = 1'b0; id_memwrite = 1'b0; redirect = 1'b0;
    reset = 1'b0;
    #1;
    model_clear();
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("rst_ctl%0d", k), int'(ctl_of(k)), 8'hF8);
    end
    check_regs("rst");
    @(posedge clockCPU);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    model_clear();
    #3;
    do_reset();

    // add x5 ; add x6,x5,x1 -> EX/MEM forward
    step(1, 1, 1, 2, 1, 5, 1, 0, 0, 0);
    step(1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
    // add x5 ; independent ; add x6,x5,x1 -> MEM/WB forward
    step(1, 1, 1, 2, 1, 5, 1, 0, 0, 0);
    step(1, 3, 1, 4, 1, 9, 1, 0, 0, 0);
    step(1, 5, 1, 1, 1, 6, 1, 0, 0, 0);
    // lw x5 ; add x7,x5,x5 (held in ID through the stall and memory wait)
    step(1, 1, 1, 0, 0, 5, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 5, 1, 5, 1, 7, 1, 0, 0, 0);
    // sw in MEM, then idle
    step(1, 2, 1, 3, 1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // lw x5 ; add x7,x5,x5 with a redirect in the same cycle
    step(1, 1, 1, 0, 0, 5, 1, 1, 0, 0);
    step(1, 5, 1, 5, 1, 7, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // write x0 ; consumer of x0 ; load to x0 ; consumer of x0
    step(1, 1, 1, 2, 1, 0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 1, 8, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 1, 1, 0, 0);
    step(1, 0, 1, 0, 1, 8, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // sw, back-to-back lw, then reset in the middle of the memory wait
    step(1, 2, 1, 3, 1, 0, 0, 0, 1, 0);
    step(1, 2, 1, 0, 0, 4, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // randomised traffic over a small register set to provoke hazards
    for (int n = 0; n < 600; n++) begin
      bit v, lr, sw, w;
      v  = ($urandom_range(0, 7) != 0);
      lr = ($urandom_range(0, 2) == 0);
      sw = !lr && ($urandom_range(0, 5) == 0);
      w  = lr || (!sw && ($urandom_range(0, 4) != 0));
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        step(v, $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
             $urandom_range(0, 1), $urandom_range(0, 3), w, lr, sw,
             ($urandom_range(0, 9) == 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard and stall controller for the 5-stage RV32 pipeline. It tracks in-flight destination registers in an internal scoreboard and produces registered forwarding selects for the EX stage. It also generates per-stage enable, flush and bubble signals for load-use hazards, control redirects and multi-cycle data memory. It sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and the top level gates its register updates with these outputs.

## Interface
- REG_W, 5, register index width
- MEM_LAT, 1, data-memory latency in cycles (≥1); values >1 insert wait states
- REDIRECT_STAGE, 0, stage resolving branches/jumps: 0 = ID, 1 = EX
- CNT_W, 16, width of the saturating performance counters
- clockCPU  in  1  pipeline clock
- reset  in  1  asynchronous, active-low reset
- id_valid, id_rs1_used, id_rs2_used  in  1 each  ID instruction valid; source fields used
- id_rs1, id_rs2, id_rd  in  REG_W each  ID register fields
- id_regwrite, id_memread, id_memwrite  in  1 each  ID control bits
- redirect  in  1  taken branch/JAL/JALR resolved in REDIRECT_STAGE
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  stage register load enables
- if_id_flush, id_ex_bubble  out  1 each  load NOP into the register instead of data
- fwd_a, fwd_b  out  2 each  EX operand source: 00 regfile, 01 EX/MEM, 10 MEM/WB
- mem_busy  out  1  memory wait in progress
- lu_stalls, mem_stalls, flushes  out  CNT_W each  saturating event counters

## Operation
- Scoreboard: entries sb[0] (EX), sb[1] (MEM), sb[2] (WB), each {valid, rd, regwrite, memread, memwrite}.
- On advance (no freeze), the entries shift up. sb[0] loads the ID entry, or an invalid entry when id_ex_bubble is set. On freeze, all entries hold.
- Match(rs, e) = e.valid & e.regwrite & e.rd≠0 & rs==e.rd & rs_used.
- Forwarding: on advance, fwd_a/fwd_b are registered. The result is 01 if the source matches sb[0], else 10 if it matches sb[1], else 00. sb[0] has priority over sb[1]. A bubble loads 00. Forwarding holds on freeze.
- Load-use: id_valid, sb[0].memread and Match on either source. Response: pc_en=0, if_id_en=0, id_ex_bubble=1. Later stages advance. Exactly 1 bubble; the stalled instruction then gets fwd 10.
- Redirect, REDIRECT_STAGE=0: if_id_flush=1. Ignored while a load-use stall is active, because decode re-asserts it next cycle.
- Redirect, REDIRECT_STAGE=1: if_id_flush=1 and id_ex_bubble=1. Overrides load-use.
- FSM states: RUN, MEMWAIT.
  - RUN→MEMWAIT when sb[1] holds a valid memread or memwrite, MEM_LAT>1, and the op has not yet been served. wait_cnt loads MEM_LAT−2.
  - MEMWAIT: all enables 0, mem_busy=1, wait_cnt decrements. At wait_cnt==0, →RUN with the served flag set, so the final cycle advances normally.
  - The served flag clears when sb[1] advances.
- Priority: memory freeze > EX redirect > load-use > ID redirect. During a freeze, flush and bubble are 0 and the redirect is held by the upstream stage.
- Counters: increment once per load-use bubble cycle, per MEMWAIT cycle, and per flush cycle. They saturate at all-ones.

## Timing
- Reset (async, active-low): scoreboard invalid, FSM RUN, wait_cnt 0, fwd 00, counters 0. All enables 1, flush/bubble 0, mem_busy 0.
- Enables, flush and bubble are combinational from the scoreboard, FSM and ID inputs, valid in the same cycle.
- fwd_a/fwd_b are registered and valid during the cycle the instruction occupies EX.
- A memory op occupies MEM for exactly MEM_LAT cycles. MEM_LAT=1 never enters MEMWAIT.
- Back-to-back memory ops each wait the full MEM_LAT cycles.
- Reset mid-MEMWAIT: immediate return to RUN, with no residual freeze after release.
- x0 is never forwarded and never stalls.

## Structure
- A shared package holds the fwd encodings (FWD_RF, FWD_EXMEM, FWD_MEMWB), the FSM state enum, and the scoreboard entry struct.
- Sub-module sat_counter (parameter CNT_W; ports inc, q) is instantiated three times.

## Test plan
- Hazard-free sequence: add x5 then add x6,x5,x1. The second instruction gets fwd_a=01; with one independent instruction between them, fwd_a=10.
- lw x5 then add x7,x5,x5: one cycle with pc_en=0, if_id_en=0, id_ex_bubble=1, lu_stalls=1. The add then reaches EX with fwd_a=fwd_b=10.
- MEM_LAT=3, sw in MEM: 2 cycles with all enables 0 and mem_busy=1, then advance. mem_stalls=2.
- REDIRECT_STAGE=1, redirect while a load-use condition is present: if_id_flush=1, id_ex_bubble=1, flushes=1, lu_stalls unchanged.
- Write to x0 followed by a consumer of x0: fwd 00, no stall.
- Reset asserted during MEMWAIT: all enables return to 1 and counters read 0 in the first cycle after release.
